mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline, directly downstream of the execute stage; consumes its registered XM_* bundle plus ALUout/ALUoutBK.
- Performs LW/SW on an internal word-addressed data memory with configurable access latency, captures DIV results into HI/LO, and serves MFHI/MFLO.
- Resolves branches toward the PC and produces the registered MW_* bundle for writeback.
- Drives a stall back to IF/ID/EX while a multi-cycle memory access is in flight.

Parameters:
DEPTH, 256, data memory depth in 32-bit words (power of two)
ADDR_W, 8, log2(DEPTH)
MEM_LAT, 1, memory access latency in cycles (>=1)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
ALUout  in  32  EX result: address for LW/SW, data for ALU ops, remainder for DIV
ALUoutBK  in  32  EX quotient for DIV
XM_RD  in  5  destination register
XM_MemCtr  in  3  op class (encoding in Decomposition)
XM_RegtoMem  in  32  SW store data
XM_BranchCtr  in  3  nonzero = branch taken
XM_BranchAddr  in  32  branch target
MW_RD  out  5  writeback register index
MW_RegWrite  out  1  writeback enable
MW_WBData  out  32  writeback data
HI  out  32  remainder register
LO  out  32  quotient register
PC_BranchTaken  out  1  one-cycle taken pulse
PC_BranchAddr  out  32  target, valid with PC_BranchTaken
mem_stall  out  1  upstream must hold its XM_* outputs
misalign_err  out  1  sticky misaligned-access flag

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM to IDLE, latency counter 0. Memory array is not cleared.
- Address: word index = ALUout[ADDR_W+1:2]; upper bits ignored, so addresses wrap modulo DEPTH.
- Misaligned (ALUout[1:0]!=0) LW/SW: SW writes nothing; LW writes back 0 with the normal latency; misalign_err set until reset.
- FSM states: IDLE, BUSY.
  - IDLE with LW/SW and MEM_LAT>1: mem_stall=1 combinationally in the same cycle; go to BUSY, cnt=1.
  - BUSY: cnt increments each cycle. mem_stall=1 while cnt<MEM_LAT-1. In the cycle cnt==MEM_LAT-1, mem_stall=0 and the access completes at that edge, returning to IDLE.
  - Total occupancy is exactly MEM_LAT cycles.
  - MEM_LAT=1: no stall; access completes at the edge it is presented.
- Input stability: inputs are held stable by upstream while mem_stall=1; the stage samples them only at completion.
- SW: memory word written at the completion edge.
- LW: MW_WBData = mem[word] at the completion edge (registered, 1 cycle after the final access cycle).
- Bubbles: during stall cycles MW_RegWrite<=0 and PC_BranchTaken<=0.
- Writeback, registered 1 cycle after acceptance/completion:
  - MW_RegWrite=1 iff op in {ALU, LW, MFHI, MFLO}, XM_RD!=0 and XM_BranchCtr==0.
  - MW_WBData per op: ALU->ALUout, LW->mem data, MFHI->HI, MFLO->LO. Otherwise 0.
  - MW_RD = XM_RD.
- DIV op: HI<=ALUout, LO<=ALUoutBK; no register write.
- MFHI/MFLO after DIV in the next cycle: the new HI/LO value is returned, because HI/LO update at the prior edge.
- Branch: XM_BranchCtr!=0 produces PC_BranchTaken=1 for exactly one cycle and PC_BranchAddr=XM_BranchAddr. A branch is never combined with a memory op, so branches never stall.
- Reset mid-BUSY: access abandoned, no memory write, mem_stall drops immediately.

Decomposition:
- Shared package, also used by the decode and execute stages:
  - MemCtr encoding: MC_ALU=0, MC_LW=1, MC_SW=2, MC_DIV=4, MC_MFHI=5, MC_MFLO=6 (3 reserved, treated as no-op with no write).
  - FSM state enum: ST_IDLE, ST_BUSY.
- One sub-module: dmem_sync (single-port synchronous RAM, DEPTH x 32, write-enable, registered read).
- FSM, HI/LO and the MW/PC registers stay in the top module.

Test Plan:
- Reset then MEM_LAT=1, SW with ALUout=0x10 and RegtoMem=0xDEADBEEF, then LW with ALUout=0x10 and RD=8 -> MW_RegWrite=1, MW_RD=8, MW_WBData=0xDEADBEEF, mem_stall never 1.
- MEM_LAT=3, LW held stable -> mem_stall high exactly 2 cycles; MW_WBData valid 1 cycle after stall drops; MW_RegWrite=0 during the stall.
- DIV with ALUout=2, ALUoutBK=5, then next cycle MFHI RD=3, then MFLO RD=4 -> HI=2, LO=5; writebacks (3,2) then (4,5).
- XM_BranchCtr=1, XM_BranchAddr=0x40 for one cycle -> PC_BranchTaken pulses 1 cycle with PC_BranchAddr=0x40.
- SW with ALUout=0x402 -> misalign_err=1 and stays 1; SW at 0x400 wraps to word 0 (DEPTH=256), confirmed by LW at 0x0.
- MEM_LAT=4, SW issued, rst pulsed low in the 2nd BUSY cycle -> all outputs 0, mem_stall=0 immediately; subsequent LW of that address returns the old value.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the decode, execute and memory stages:
// op-class encoding carried on *_MemCtr, memory FSM states and op helpers.
package mem_access_stage_pkg;

  // Op classes carried on MemCtr (3 is reserved and behaves as a no-op)
  localparam logic [2:0] MC_ALU  = 3'd0;
  localparam logic [2:0] MC_LW   = 3'd1;
  localparam logic [2:0] MC_SW   = 3'd2;
  localparam logic [2:0] MC_DIV  = 3'd4;
  localparam logic [2:0] MC_MFHI = 3'd5;
  localparam logic [2:0] MC_MFLO = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_t;

  // Ops that touch the data memory
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == MC_LW) || (op == MC_SW);
  endfunction

  // Ops that produce a register writeback value
  function automatic logic is_wb_op(input logic [2:0] op);
    return (op == MC_ALU) || (op == MC_LW) || (op == MC_MFHI) || (op == MC_MFLO);
  endfunction

endpackage

// File: rtl/mem_access_stage_dmem_sync.sv
// Single-port synchronous data RAM, DEPTH x 32, with write enable and a
// registered read port that only updates when a read is requested.
module dmem_sync #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_array [DEPTH];

  // Write port and registered read port; contents are never cleared
  always_ff @(posedge clk) begin
    if (we) mem_array[addr] <= wdata;
    if (re) rdata <= mem_array[addr];
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data memory access with configurable latency, HI/LO capture
// for DIV, MFHI/MFLO, branch resolution towards the PC and the registered
// MW_* writeback bundle. Stalls upstream while a memory access is in flight.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUout,
  input  logic [31:0] ALUoutBK,
  input  logic [4:0]  XM_RD,
  input  logic [2:0]  XM_MemCtr,
  input  logic [31:0] XM_RegtoMem,
  input  logic [2:0]  XM_BranchCtr,
  input  logic [31:0] XM_BranchAddr,
  output logic [4:0]  MW_RD,
  output logic        MW_RegWrite,
  output logic [31:0] MW_WBData,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        PC_BranchTaken,
  output logic [31:0] PC_BranchAddr,
  output logic        mem_stall,
  output logic        misalign_err
);

  localparam bit                MULTI    = (MEM_LAT > 1);
  localparam int                CNT_W    = MULTI ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LAT - 1);

  mem_state_t        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              stall_raw;
  logic              accept;
  logic              is_mem;
  logic              aligned;
  logic              is_branch;
  logic [ADDR_W-1:0] word_addr;
  logic              ram_we;
  logic              ram_re;
  logic [31:0]       ram_rdata;
  logic [31:0]       wb_data_reg;
  logic              wb_mem_sel_reg;
  logic              addr_hi_unused;

  assign is_mem         = is_mem_op(XM_MemCtr);
  assign aligned        = (ALUout[1:0] == 2'b00);
  assign is_branch      = (XM_BranchCtr != 3'd0);
  assign word_addr      = ALUout[ADDR_W+1:2];
  assign addr_hi_unused = ^ALUout[31:ADDR_W+2];

  // Stall covers every occupancy cycle except the last one, where the access completes
  always_comb begin
    stall_raw = 1'b0;
    if (state_reg == ST_IDLE) stall_raw = is_mem && MULTI;
    else                      stall_raw = (cnt_reg != CNT_LAST);
  end

  // Gated by reset so an abandoned access releases upstream immediately
  assign mem_stall = rst & stall_raw;
  assign accept    = ~stall_raw;

  // Misaligned accesses never touch the array; writes are also blocked in reset
  assign ram_we = rst & accept & (XM_MemCtr == MC_SW) & aligned;
  assign ram_re = accept & (XM_MemCtr == MC_LW) & aligned;

  dmem_sync #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (word_addr),
    .wdata (XM_RegtoMem),
    .rdata (ram_rdata)
  );

  // Latency FSM: IDLE -> BUSY counting up to MEM_LAT-1, then back to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (is_mem && MULTI) begin
            state_reg <= ST_BUSY;
            cnt_reg   <= CNT_W'(1);
          end
        end
        default: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // HI/LO capture on DIV and the sticky misalignment flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      HI           <= '0;
      LO           <= '0;
      misalign_err <= 1'b0;
    end else if (accept) begin
      if (XM_MemCtr == MC_DIV) begin
        HI <= ALUout;
        LO <= ALUoutBK;
      end
      if (is_mem && !aligned) misalign_err <= 1'b1;
    end
  end

  // Writeback and branch registers; stall cycles become bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MW_RD          <= '0;
      MW_RegWrite    <= 1'b0;
      wb_data_reg    <= '0;
      wb_mem_sel_reg <= 1'b0;
      PC_BranchTaken <= 1'b0;
      PC_BranchAddr  <= '0;
    end else if (accept) begin
      MW_RD          <= XM_RD;
      MW_RegWrite    <= is_wb_op(XM_MemCtr) && (XM_RD != 5'd0) && !is_branch;
      wb_mem_sel_reg <= (XM_MemCtr == MC_LW) && aligned;
      case (XM_MemCtr)
        MC_ALU:  wb_data_reg <= ALUout;
        MC_MFHI: wb_data_reg <= HI;
        MC_MFLO: wb_data_reg <= LO;
        default: wb_data_reg <= '0;
      endcase
      PC_BranchTaken <= is_branch;
      if (is_branch) PC_BranchAddr <= XM_BranchAddr;
    end else begin
      MW_RegWrite    <= 1'b0;
      PC_BranchTaken <= 1'b0;
    end
  end

  // Load data comes straight from the RAM read register, which was loaded at completion
  assign MW_WBData = wb_mem_sel_reg ? ram_rdata : wb_data_reg;

endmodule
